// File: rtl/vx_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// vx_mem_bridge_pkg
// Shared types and helpers for the Vortex-to-Wishbone memory bridge.
//   state_e      : bridge FSM states (IDLE / XFER / RESP)
//   beats()      : number of bus beats per Vortex line
//   beat_sel_w() : width of the beat index counter
//   req_t        : latched request control fields (rw, line address, tag)
// The address and tag fields of req_t are sized to fixed maxima so one
// package type serves every parameterisation; the bridge zero-extends into
// them on acceptance and narrows back on use.
// -----------------------------------------------------------------------------
package vx_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int REQ_ADDR_MAX_W = 48;
  localparam int REQ_TAG_MAX_W  = 32;

  typedef struct packed {
    logic                      rw;
    logic [REQ_ADDR_MAX_W-1:0] addr;
    logic [REQ_TAG_MAX_W-1:0]  tag;
  } req_t;

  function automatic int beats(input int mem_data_w, input int bus_data_w);
    return mem_data_w / bus_data_w;
  endfunction

  // At least one counter bit, even for a single-beat line.
  function automatic int beat_sel_w(input int mem_data_w, input int bus_data_w);
    int n;
    n = beats(mem_data_w, bus_data_w);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/vx_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// Bus bundles for vx_mem_bridge.
//   vx_mem_bridge_if    : Vortex memory port (request + response channels).
//                         master = core side, slave = bridge side.
//   vx_mem_bridge_wb_if : classic Wishbone bus.
//                         master = bridge side, slave = memory side.
// -----------------------------------------------------------------------------
interface vx_mem_bridge_if #(
  parameter int MEM_DATA_W = 512,
  parameter int MEM_ADDR_W = 26,
  parameter int MEM_TAG_W  = 8
);
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [MEM_DATA_W/8-1:0] mem_req_byteen;
  logic [MEM_ADDR_W-1:0]   mem_req_addr;
  logic [MEM_DATA_W-1:0]   mem_req_data;
  logic [MEM_TAG_W-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [MEM_DATA_W-1:0]   mem_rsp_data;
  logic [MEM_TAG_W-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
           mem_req_data, mem_req_tag, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

interface vx_mem_bridge_wb_if #(
  parameter int BUS_DATA_W = 32,
  parameter int BUS_ADDR_W = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [BUS_ADDR_W-1:0]   adr;
  logic [BUS_DATA_W/8-1:0] sel;
  logic [BUS_DATA_W-1:0]   dat_w;
  logic [BUS_DATA_W-1:0]   dat_r;
  logic                    ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/vx_beat_serdes.sv
// -----------------------------------------------------------------------------
// vx_beat_serdes
// Line register shared by both transfer directions, addressed one bus beat
// at a time.
//   clk        in  clock
//   i_load     in  load the whole line (request acceptance)
//   i_line     in  line to load
//   i_wr_en    in  overwrite the slice selected by i_sel (read capture)
//   i_sel      in  beat index; beat 0 is the least significant slice
//   i_wr_slice in  slice data for i_wr_en
//   o_slice    out slice selected by i_sel (write beat data)
//   o_line     out full line (read response data)
// The line holds data only, so it carries no reset. LINE_W/SLICE_W must be a
// power of two so every i_sel value addresses a real slice.
// -----------------------------------------------------------------------------
module vx_beat_serdes #(
  parameter int LINE_W  = 512,
  parameter int SLICE_W = 32,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               i_load,
  input  logic [LINE_W-1:0]  i_line,
  input  logic               i_wr_en,
  input  logic [SEL_W-1:0]   i_sel,
  input  logic [SLICE_W-1:0] i_wr_slice,
  output logic [SLICE_W-1:0] o_slice,
  output logic [LINE_W-1:0]  o_line
);

  logic [LINE_W-1:0] r_line;

  // Line storage: full load on acceptance, single-slice update on capture.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_line <= i_line;
    end else if (i_wr_en) begin
      r_line[int'(i_sel)*SLICE_W +: SLICE_W] <= i_wr_slice;
    end
  end

  assign o_slice = r_line[int'(i_sel)*SLICE_W +: SLICE_W];
  assign o_line  = r_line;

endmodule

// File: rtl/vx_mem_bridge.sv
// -----------------------------------------------------------------------------
// vx_mem_bridge
// Accepts one Vortex line request at a time and serialises it into
// BUS_DATA_W-bit beats on a classic Wishbone master. Read beats are gathered
// back into a line and returned with the original tag; writes give no response.
//   clk, reset : clock, synchronous active-high reset
//   vx         : Vortex memory port (slave side)
//   wb         : Wishbone bus (master side)
//   busy       : high whenever the FSM is not IDLE
// Build option VX_MEM_BRIDGE_WSKIP_EN: write beats whose byte-enable slice is
// all zero are skipped (one cycle each, no strobe) instead of being issued
// with wb.sel = 0.
// Constraints: line/bus ratio a power of two, MEM_ADDR_W <= 48, MEM_TAG_W <= 32.
// -----------------------------------------------------------------------------
module vx_mem_bridge
  import vx_mem_bridge_pkg::*;
#(
  parameter int                    MEM_DATA_W = 512,
  parameter int                    MEM_ADDR_W = 26,
  parameter int                    MEM_TAG_W  = 8,
  parameter int                    BUS_DATA_W = 32,
  parameter int                    BUS_ADDR_W = 32,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  vx_mem_bridge_if.slave             vx,
  vx_mem_bridge_wb_if.master         wb,
  output logic                       busy
);

  localparam int BEATS      = beats(MEM_DATA_W, BUS_DATA_W);
  localparam int BEAT_SEL_W = beat_sel_w(MEM_DATA_W, BUS_DATA_W);
  localparam int SEL_W      = BUS_DATA_W / 8;
  localparam int OFF_W      = $clog2(SEL_W);
  localparam int ADR_W      = REQ_ADDR_MAX_W + BEAT_SEL_W + OFF_W;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [BEAT_SEL_W-1:0]   r_cnt;
  logic [BEAT_SEL_W-1:0]   w_cnt_nxt;
  logic                    r_ready;
  req_t                    r_req;
  req_t                    w_req;
  logic [MEM_DATA_W/8-1:0] r_byteen;

  logic                    w_accept;
  logic                    w_skip;
  logic                    w_strobe;
  logic                    w_beat_done;
  logic                    w_last;
  logic                    w_capture;
  logic [SEL_W-1:0]        w_be_slice;
  logic [BUS_DATA_W-1:0]   w_beat_data;
  logic [ADR_W-1:0]        w_off;

  // r_ready is only ever set while heading into IDLE, so it doubles as "in IDLE".
  assign w_accept    = vx.mem_req_valid && r_ready;
  assign w_be_slice  = r_byteen[int'(r_cnt)*SEL_W +: SEL_W];
  assign w_last      = (r_cnt == BEAT_SEL_W'(BEATS - 1));

`ifdef VX_MEM_BRIDGE_WSKIP_EN
  assign w_skip      = (r_state == XFER) && r_req.rw && (w_be_slice == {SEL_W{1'b0}});
`else
  assign w_skip      = 1'b0;
`endif

  assign w_strobe    = (r_state == XFER) && !w_skip;
  // A skipped beat completes on its own; an issued beat completes on ack.
  assign w_beat_done = (r_state == XFER) && (w_skip || wb.ack);
  assign w_capture   = w_strobe && wb.ack && !r_req.rw;

  // Request fields widened into the package struct for latching.
  always_comb begin
    w_req      = '0;
    w_req.rw   = vx.mem_req_rw;
    w_req.addr = REQ_ADDR_MAX_W'(vx.mem_req_addr);
    w_req.tag  = REQ_TAG_MAX_W'(vx.mem_req_tag);
  end

  // Next-state and beat-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = XFER;
          w_cnt_nxt   = {BEAT_SEL_W{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        if (w_beat_done) begin
          if (w_last) begin
            w_state_nxt = r_req.rw ? IDLE : RESP;
          end else begin
            w_cnt_nxt = r_cnt + BEAT_SEL_W'(1'b1);
          end
        end else begin
          w_state_nxt = XFER;
        end
      end
      RESP: begin
        if (vx.mem_rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {BEAT_SEL_W{1'b0}};
      end
    endcase
  end

  // State, counter and ready registers; ready is held low through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= {BEAT_SEL_W{1'b0}};
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  // Request control/byte-enable capture at acceptance (data-only, no reset).
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_req    <= w_req;
      r_byteen <= vx.mem_req_byteen;
    end
  end

  vx_beat_serdes #(
    .LINE_W  (MEM_DATA_W),
    .SLICE_W (BUS_DATA_W),
    .SEL_W   (BEAT_SEL_W)
  ) u_serdes (
    .clk        (clk),
    .i_load     (w_accept),
    .i_line     (vx.mem_req_data),
    .i_wr_en    (w_capture),
    .i_sel      (r_cnt),
    .i_wr_slice (wb.dat_r),
    .o_slice    (w_beat_data),
    .o_line     (vx.mem_rsp_data)
  );

  // Byte offset of the current beat; the sum wraps at the bus address width.
  assign w_off = {r_req.addr, r_cnt, {OFF_W{1'b0}}};

  assign wb.cyc   = w_strobe;
  assign wb.stb   = w_strobe;
  assign wb.we    = w_strobe && r_req.rw;
  assign wb.adr   = BUS_ADDR_W'(w_off + ADR_W'(BASE_ADDR));
  assign wb.sel   = !w_strobe ? {SEL_W{1'b0}} : (r_req.rw ? w_be_slice : {SEL_W{1'b1}});
  assign wb.dat_w = w_beat_data;

  assign vx.mem_req_ready = r_ready;
  assign vx.mem_rsp_valid = (r_state == RESP);
  assign vx.mem_rsp_tag   = MEM_TAG_W'(r_req.tag);
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_vx_mem_bridge.sv
module tb_vx_mem_bridge;

  localparam int MDW   = 512;
  localparam int MAW   = 26;
  localparam int MTW   = 8;
  localparam int BDW   = 32;
  localparam int BAW   = 32;
  localparam int BEATS = MDW / BDW;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFC0;
`ifdef VX_MEM_BRIDGE_WSKIP_EN
  localparam bit WSKIP = 1'b1;
`else
  localparam bit WSKIP = 1'b0;
`endif

  typedef struct {
    bit          strobe;
    bit          ack;
    int          beat;
    logic [31:0] adr;
    logic [31:0] adr_b;
    logic [3:0]  sel;
    logic [31:0] dat;
  } slot_t;

  logic clk = 1'b0;
  logic reset;
  logic busy_a, busy_b;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem_words [int unsigned];

  always #5 clk = ~clk;

  vx_mem_bridge_if    #(.MEM_DATA_W(MDW), .MEM_ADDR_W(MAW), .MEM_TAG_W(MTW)) vx_a ();
  vx_mem_bridge_if    #(.MEM_DATA_W(MDW), .MEM_ADDR_W(MAW), .MEM_TAG_W(MTW)) vx_b ();
  vx_mem_bridge_wb_if #(.BUS_DATA_W(BDW), .BUS_ADDR_W(BAW)) wb_a ();
  vx_mem_bridge_wb_if #(.BUS_DATA_W(BDW), .BUS_ADDR_W(BAW)) wb_b ();

  // Second bridge with a wrapping base address runs in lockstep with the first.
  assign vx_b.mem_req_valid  = vx_a.mem_req_valid;
  assign vx_b.mem_req_rw     = vx_a.mem_req_rw;
  assign vx_b.mem_req_byteen = vx_a.mem_req_byteen;
  assign vx_b.mem_req_addr   = vx_a.mem_req_addr;
  assign vx_b.mem_req_data   = vx_a.mem_req_data;
  assign vx_b.mem_req_tag    = vx_a.mem_req_tag;
  assign vx_b.mem_rsp_ready  = vx_a.mem_rsp_ready;
  assign wb_b.dat_r          = wb_a.dat_r;
  assign wb_b.ack            = wb_a.ack;

  vx_mem_bridge #(.MEM_DATA_W(MDW), .MEM_ADDR_W(MAW), .MEM_TAG_W(MTW),
                  .BUS_DATA_W(BDW), .BUS_ADDR_W(BAW), .BASE_ADDR(BASE_A)) dut_a (
    .clk(clk), .reset(reset), .vx(vx_a), .wb(wb_a), .busy(busy_a));

  vx_mem_bridge #(.MEM_DATA_W(MDW), .MEM_ADDR_W(MAW), .MEM_TAG_W(MTW),
                  .BUS_DATA_W(BDW), .BUS_ADDR_W(BAW), .BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .vx(vx_b), .wb(wb_b), .busy(busy_b));

  task automatic check(input string tag, input logic [MDW-1:0] obs, input logic [MDW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory contents seen on the bus: explicit entries, otherwise an address hash.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Byte address of beat k of line addr, modulo 2^32.
  function automatic logic [31:0] beat_adr(input logic [31:0] base, input logic [MAW-1:0] addr, input int k);
    logic [63:0] a;
    a = 64'(base) + (64'(addr) << 6) + 64'(k * 4);
    return a[31:0];
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      wb_a.ack   = 1'($urandom);
      wb_a.dat_r = $urandom;
      @(posedge clk); @(negedge clk);
      check("idle_busy",  MDW'(busy_a), MDW'(1'b0));
      check("idle_cyc",   MDW'(wb_a.cyc), MDW'(1'b0));
      check("idle_ready", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
      check("idle_rsp",   MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
    end
    wb_a.ack = 1'b0;
  endtask

  // One request end to end. abort_beat >= 0 asserts reset while that beat is strobed.
  task automatic run_txn(input logic rw, input logic [MAW-1:0] addr, input logic [MDW/8-1:0] be,
                         input logic [MDW-1:0] data, input logic [MTW-1:0] tag,
                         input int wait_n, input int hold_n, input int abort_beat);
    slot_t sched[$];
    slot_t s;
    logic [MDW-1:0] exp_line;
    exp_line = '0;
    // Cycle-by-cycle schedule: a skipped beat takes one idle cycle, an issued
    // beat holds its strobe for wait_n cycles and is acked in the next one.
    for (int k = 0; k < BEATS; k++) begin
      s.beat  = k;
      s.adr   = beat_adr(BASE_A, addr, k);
      s.adr_b = beat_adr(BASE_B, addr, k);
      s.sel   = rw ? be[k*4 +: 4] : 4'hF;
      s.dat   = data[k*32 +: 32];
      exp_line[k*32 +: 32] = rd_word(s.adr);
      if (WSKIP && rw && (be[k*4 +: 4] == 4'h0)) begin
        s.strobe = 1'b0; s.ack = 1'b0;
        sched.push_back(s);
      end else begin
        for (int w = 0; w <= wait_n; w++) begin
          s.strobe = 1'b1; s.ack = (w == wait_n);
          sched.push_back(s);
        end
      end
    end

    check("req_ready", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
    vx_a.mem_req_valid  = 1'b1;
    vx_a.mem_req_rw     = rw;
    vx_a.mem_req_addr   = addr;
    vx_a.mem_req_byteen = be;
    vx_a.mem_req_data   = data;
    vx_a.mem_req_tag    = tag;
    vx_a.mem_rsp_ready  = 1'b0;
    @(posedge clk); @(negedge clk);
    // Request lines change after acceptance; the bridge must have latched them.
    vx_a.mem_req_valid  = 1'b0;
    vx_a.mem_req_rw     = ~rw;
    vx_a.mem_req_addr   = MAW'($urandom);
    vx_a.mem_req_byteen = ~be;
    vx_a.mem_req_data   = ~data;
    vx_a.mem_req_tag    = ~tag;

    for (int c = 0; c < sched.size(); c++) begin
      s = sched[c];
      check("xfer_busy", MDW'(busy_a), MDW'(1'b1));
      check("xfer_rsp",  MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
      check("cyc",   MDW'(wb_a.cyc), MDW'(s.strobe));
      check("stb",   MDW'(wb_a.stb), MDW'(s.strobe));
      check("cyc_b", MDW'(wb_b.cyc), MDW'(s.strobe));
      if (s.strobe) begin
        check("adr",   MDW'(wb_a.adr), MDW'(s.adr));
        check("adr_b", MDW'(wb_b.adr), MDW'(s.adr_b));
        check("we",    MDW'(wb_a.we),  MDW'(rw));
        check("sel",   MDW'(wb_a.sel), MDW'(s.sel));
        if (rw) check("dat_w", MDW'(wb_a.dat_w), MDW'(s.dat));
        if (s.beat == abort_beat) begin
          reset = 1'b1;
          wb_a.ack = 1'b1; wb_a.dat_r = $urandom;
          @(posedge clk); @(negedge clk);
          reset = 1'b0; wb_a.ack = 1'b0;
          check("rst_cyc",  MDW'(wb_a.cyc), MDW'(1'b0));
          check("rst_stb",  MDW'(wb_a.stb), MDW'(1'b0));
          check("rst_rsp",  MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
          check("rst_busy", MDW'(busy_a), MDW'(1'b0));
          @(posedge clk); @(negedge clk);
          check("rst_ready_after", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
          check("rst_rsp_after",   MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
          check("rst_cyc_after",   MDW'(wb_a.cyc), MDW'(1'b0));
          return;
        end
        wb_a.ack   = s.ack;
        wb_a.dat_r = s.ack ? rd_word(s.adr) : $urandom;
      end else begin
        wb_a.ack   = 1'b0;
        wb_a.dat_r = $urandom;
      end
      @(posedge clk); @(negedge clk);
    end
    wb_a.ack = 1'b0;

    check("done_cyc", MDW'(wb_a.cyc), MDW'(1'b0));
    if (rw) begin
      check("wr_ready", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
      check("wr_norsp", MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
      check("wr_busy",  MDW'(busy_a), MDW'(1'b0));
    end else begin
      for (int h = 0; h <= hold_n; h++) begin
        if (h > 0) begin
          @(posedge clk); @(negedge clk);
        end
        check("rsp_valid", MDW'(vx_a.mem_rsp_valid), MDW'(1'b1));
        check("rsp_data",  vx_a.mem_rsp_data, exp_line);
        check("rsp_tag",   MDW'(vx_a.mem_rsp_tag), MDW'(tag));
        check("rsp_ready_blocked", MDW'(vx_a.mem_req_ready), MDW'(1'b0));
      end
      vx_a.mem_rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      vx_a.mem_rsp_ready = 1'b0;
      check("rsp_done",   MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
      check("rsp_ready1", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
    end
  endtask

  initial begin
    logic [MDW-1:0]   d;
    logic [MDW/8-1:0] be;
    reset = 1'b1;
    vx_a.mem_req_valid = 1'b0; vx_a.mem_req_rw = 1'b0; vx_a.mem_req_byteen = '0;
    vx_a.mem_req_addr = '0; vx_a.mem_req_data = '0; vx_a.mem_req_tag = '0;
    vx_a.mem_rsp_ready = 1'b0; wb_a.ack = 1'b0; wb_a.dat_r = '0;

    // Reset state.
    @(posedge clk); @(negedge clk);
    check("rst_ready", MDW'(vx_a.mem_req_ready), MDW'(1'b0));
    check("rst_cyc0",  MDW'(wb_a.cyc), MDW'(1'b0));
    check("rst_stb0",  MDW'(wb_a.stb), MDW'(1'b0));
    check("rst_we0",   MDW'(wb_a.we),  MDW'(1'b0));
    check("rst_sel0",  MDW'(wb_a.sel), MDW'(4'h0));
    check("rst_busy0", MDW'(busy_a),   MDW'(1'b0));
    check("rst_rsp0",  MDW'(vx_a.mem_rsp_valid), MDW'(1'b0));
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", MDW'(vx_a.mem_req_ready), MDW'(1'b1));
    idle_cycles(2);

    // Directed read: line 0x10, bus returns the beat index.
    for (int k = 0; k < BEATS; k++) mem_words[32'h400 + 32'(k*4)] = 32'(k);
    run_txn(1'b0, MAW'(32'h10), '1, '0, 8'h5A, 0, 0, -1);

    // Directed write: line 1, full byte enables; base-B instance wraps to 0.
    for (int k = 0; k < BEATS; k++) d[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
    run_txn(1'b1, MAW'(32'h1), '1, d, 8'h00, 0, 0, -1);

    // Read with wait states and a stalled response.
    run_txn(1'b0, MAW'($urandom), '1, '0, MTW'($urandom), 3, 5, -1);

    // Write with only beat 3 enabled, then a write with nothing enabled.
    for (int k = 0; k < BEATS; k++) d[k*32 +: 32] = $urandom;
    be = '0; be[15:12] = 4'hF;
    run_txn(1'b1, MAW'(32'h0), be, d, 8'h11, 0, 0, -1);
    run_txn(1'b1, MAW'($urandom), '0, d, 8'h22, 1, 0, -1);
    idle_cycles(1);

    // Randomised traffic.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < BEATS; k++) begin
        d[k*32 +: 32] = $urandom;
        be[k*4 +: 4]  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      end
      run_txn(1'($urandom), MAW'($urandom), be, d, MTW'($urandom),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
    end

    // Reset during beat 7 of a read, then recovery.
    run_txn(1'b0, MAW'($urandom), '1, '0, 8'h77, 0, 0, 7);
    idle_cycles(2);
    run_txn(1'b0, MAW'($urandom), '1, '0, 8'h33, 1, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
